// File: rtl/led_message_scroller_pkg.sv
// led_message_scroller_pkg: state encoding, default message and width helper shared by the scroller
package led_message_scroller_pkg;
  typedef enum logic {RUN = 1'b0, PAUSE = 1'b1} state_e;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic logic [3:0] default_char(input int i);
    return 4'(i % 16);
  endfunction
endpackage

// File: rtl/led_message_scroller_debouncer.sv
// button_debouncer: synchronises a raw pushbutton and accepts a level change only after a stable run
module button_debouncer
  import led_message_scroller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  localparam int CW = clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_rise
);
  logic sync1_q, sync2_q, level_q, rise_q, flip;
  logic [CW-1:0] cnt_q;
  assign flip = (sync2_q != level_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
  // two-flop synchroniser, then count consecutive mismatches; a matching cycle restarts the count
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      cnt_q   <= (sync2_q == level_q || flip) ? '0 : cnt_q + 1'b1;
      level_q <= level_q ^ flip;
      rise_q  <= flip && !level_q;
    end
  end
  assign btn_level = level_q;
  assign btn_rise  = rise_q;
endmodule

// File: rtl/led_message_scroller.sv
// led_message_scroller: scrolls a 4-character window over an editable hex message for the LED driver
module led_message_scroller
  import led_message_scroller_pkg::*;
#(
  parameter int MSG_LEN = 16,
  parameter int SCROLL_PERIOD = 25000000,
  parameter int DEBOUNCE_CYCLES = 500000,
  localparam int AW = clog2(MSG_LEN),
  localparam int TW = clog2(SCROLL_PERIOD)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          btn_pause,
  input  logic          btn_step,
  input  logic          msg_we,
  input  logic [AW-1:0] msg_wr_addr,
  input  logic [3:0]    msg_wr_data,
  output logic [3:0]    char3,
  output logic [3:0]    char2,
  output logic [3:0]    char1,
  output logic [3:0]    char0,
  output logic          char_update,
  output logic          paused,
  output logic [AW-1:0] pos
);
  state_e        state_q, state_d;
  logic [AW-1:0] pos_q, pos_d, off;
  logic [TW-1:0] tick_q, tick_d;
  logic [3:0]    mem_q [MSG_LEN];
  logic [3:0]    win_q [4];
  logic          reload_q, reload_d, upd_q, adv;
  logic          pause_level, pause_rise, step_level, step_rise, pause_ev, step_ev;
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause (
    .clk(clk), .reset(reset), .btn_raw(btn_pause), .btn_level(pause_level), .btn_rise(pause_rise)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
    .clk(clk), .reset(reset), .btn_raw(btn_step), .btn_level(step_level), .btn_rise(step_rise)
  );
  // a rise always coincides with the level going high; requiring both keeps the event tied to a held press
  always_comb begin
    pause_ev = pause_rise & pause_level;
    step_ev  = step_rise & step_level;
    adv      = (state_q == RUN) ? (tick_q == TW'(SCROLL_PERIOD - 1)) : step_ev;
    state_d  = pause_ev ? state_e'(~state_q) : state_q;
    tick_d   = (state_q == PAUSE || state_d == PAUSE || adv) ? '0 : tick_q + 1'b1;
    pos_d    = pos_q + AW'(adv);
    off      = msg_wr_addr - pos_d;
    reload_d = adv || (msg_we && off <= AW'(3));
  end
  // state, position, message memory, and window reload one cycle after any visible change
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      pos_q    <= '0;
      tick_q   <= '0;
      reload_q <= 1'b0;
      upd_q    <= 1'b0;
      for (int i = 0; i < MSG_LEN; i++) mem_q[i] <= default_char(i);
      for (int k = 0; k < 4; k++) win_q[k] <= default_char(k);
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      tick_q   <= tick_d;
      reload_q <= reload_d;
      upd_q    <= reload_q;
      if (msg_we) mem_q[msg_wr_addr] <= msg_wr_data;
      if (reload_q) for (int k = 0; k < 4; k++) win_q[k] <= mem_q[pos_q + AW'(k)];
    end
  end
  assign char3       = win_q[0];
  assign char2       = win_q[1];
  assign char1       = win_q[2];
  assign char0       = win_q[3];
  assign char_update = upd_q;
  assign paused      = state_q;
  assign pos         = pos_q;
endmodule

// File: tb/tb_led_message_scroller.sv
// tb_led_message_scroller: reference model plus directed scenarios for the message scroller
module tb_led_message_scroller;
  localparam int L = 16, SP = 4, D = 3;
  logic clk = 0, reset = 1, btn_pause = 0, btn_step = 0, msg_we = 0;
  logic [3:0] msg_wr_addr = 0, msg_wr_data = 0;
  logic [3:0] char3, char2, char1, char0, pos;
  logic char_update, paused;
  int n_pass = 0, n_total = 0;
  always #5 clk = ~clk;
  led_message_scroller #(.MSG_LEN(L), .SCROLL_PERIOD(SP), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .btn_pause(btn_pause), .btn_step(btn_step), .msg_we(msg_we),
    .msg_wr_addr(msg_wr_addr), .msg_wr_data(msg_wr_data), .char3(char3), .char2(char2),
    .char1(char1), .char0(char0), .char_update(char_update), .paused(paused), .pos(pos)
  );
  int m_mem[L];
  int m_ch[4];
  int m_pos, m_tick;
  bit m_paused, m_upd, m_pend, m_started, m_adv, m_np;
  bit hp[D+2], hs[D+2];
  bit lp, ls, rp, rs, fp, fs;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_pos(input int p);
    for (int i = 0; i < 200 && pos !== 4'(p); i++) tick(1);
    check("reach_pos", 32'(pos), 32'(p));
  endtask
  // model: a button level flips when the last D synchronised samples all disagree with it
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < L; i++) m_mem[i] = i % 16;
      for (int k = 0; k < 4; k++) m_ch[k] = k;
      m_pos = 0; m_tick = 0; m_paused = 0; m_upd = 0; m_pend = 0; m_started = 1;
      for (int k = 0; k < D + 2; k++) begin hp[k] = 0; hs[k] = 0; end
      lp = 0; ls = 0; rp = 0; rs = 0;
    end else begin
      if (m_pend) for (int k = 0; k < 4; k++) m_ch[k] = m_mem[(m_pos + k) % L];
      m_upd = m_pend;
      m_adv = m_paused ? rs : (m_tick == SP - 1);
      m_np = m_paused ^ rp;
      m_tick = (m_paused || m_np || m_tick == SP - 1) ? 0 : m_tick + 1;
      m_pos = (m_pos + int'(m_adv)) % L;
      m_paused = m_np;
      if (msg_we) m_mem[msg_wr_addr] = int'(msg_wr_data);
      m_pend = m_adv || (msg_we && ((int'(msg_wr_addr) - m_pos + L) % L) < 4);
      for (int k = D + 1; k > 0; k--) begin hp[k] = hp[k-1]; hs[k] = hs[k-1]; end
      hp[0] = btn_pause; hs[0] = btn_step;
      fp = 1; fs = 1;
      for (int k = 2; k <= D + 1; k++) begin
        if (hp[k] == lp) fp = 0;
        if (hs[k] == ls) fs = 0;
      end
      rp = fp && !lp; rs = fs && !ls;
      lp ^= fp; ls ^= fs;
    end
  end
  // every cycle after the first reset edge the outputs must match the model
  always @(negedge clk)
    if (m_started)
      check("model", {char3, char2, char1, char0, char_update, paused, pos},
            {4'(m_ch[0]), 4'(m_ch[1]), 4'(m_ch[2]), 4'(m_ch[3]), m_upd, m_paused, 4'(m_pos)});
  initial begin
    int seen;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 0;
    check("rst_chars", {char3, char2, char1, char0}, 16'h0123);
    check("rst_paused", paused, 0);
    check("rst_upd", char_update, 0);
    tick(4);
    check("first_adv_pos", pos, 1);
    tick(1);
    check("first_adv_chars", {char3, char2, char1, char0, char_update}, {16'h1234, 1'b1});
    tick(1);
    check("upd_single", char_update, 0);
    wait_pos(13);
    tick(1);
    check("pos13_chars", {char3, char2, char1, char0}, 16'hDEF0);
    wait_pos(0);
    tick(1);
    check("wrap_chars", {char3, char2, char1, char0}, 16'h0123);
    btn_pause = 1;
    seen = 99;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      if (paused && seen == 99) seen = i;
    end
    btn_pause = 0;
    check("pause_latency_ok", 32'(seen <= 6), 1);
    tick(40);
    check("frozen", {char3, char2, char1, char0, paused, pos}, {16'h1234, 1'b1, 4'd1});
    btn_step = 1;
    tick(8);
    btn_step = 0;
    tick(10);
    check("step", {char3, char2, char1, char0, pos}, {16'h2345, 4'd2});
    btn_pause = 1;
    for (int i = 0; i < 10 && paused; i++) tick(1);
    check("resume", {paused, pos}, {1'b0, 4'd2});
    tick(3);
    check("tick_restart_hold", pos, 2);
    tick(1);
    check("tick_restart_adv", pos, 3);
    for (int i = 0; i < 20; i++) begin
      btn_pause = (i % 4) >= 2;
      tick(1);
    end
    btn_pause = 0;
    tick(8);
    check("bounce_ignored", {paused, pos}, {1'b0, 4'd10});
    wait_pos(15);
    btn_pause = 1;
    tick(8);
    btn_pause = 0;
    tick(4);
    check("pause_at0", {char3, char2, char1, char0, paused, pos}, {16'h0123, 1'b1, 4'd0});
    msg_we = 1; msg_wr_addr = 1; msg_wr_data = 4'hA;
    tick(1);
    msg_we = 0;
    tick(1);
    check("write_in_win", {char3, char2, char1, char0, char_update}, {16'h0A23, 1'b1});
    msg_we = 1; msg_wr_addr = 9; msg_wr_data = 4'h5;
    tick(1);
    msg_we = 0;
    tick(1);
    check("write_out_win", {char3, char2, char1, char0, char_update}, {16'h0A23, 1'b0});
    for (int s = 0; s < 5; s++) begin
      btn_step = 1;
      tick(8);
      btn_step = 0;
      tick(8);
    end
    check("steps_to5", {paused, pos}, {1'b1, 4'd5});
    msg_we = 1; msg_wr_addr = 0; msg_wr_data = 4'hF;
    tick(1);
    msg_we = 0;
    tick(1);
    reset = 1;
    tick(2);
    reset = 0;
    check("reset_in_pause", {char3, char2, char1, char0, char_update, paused, pos},
          {16'h0123, 1'b0, 1'b0, 4'd0});
    tick(65);
    check("mem_restored", {char3, char2, char1, char0, pos}, {16'h0123, 4'd0});
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/led_message_scroller.md
Name: led_message_scroller

Overview:
Upstream feeder for the four-digit seven-segment LED driver. It holds a MSG_LEN-entry message of 4-bit hex characters and presents a sliding 4-character window (char3..char0) for the driver to decode and multiplex. The window advances automatically every SCROLL_PERIOD cycles. Debounced buttons pause scrolling or single-step it, and a write port allows message entries to be replaced at runtime.

Parameters:
MSG_LEN, 16, message length in characters; power of two, 4..16
SCROLL_PERIOD, 25000000, clock cycles per automatic advance (>=2)
DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed before a button change is accepted (>=2)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
btn_pause  input  1  raw asynchronous pushbutton; a debounced press toggles RUN/PAUSE
btn_step  input  1  raw asynchronous pushbutton; a debounced press advances one position while in PAUSE
msg_we  input  1  message write enable
msg_wr_addr  input  clog2(MSG_LEN)  write address
msg_wr_data  input  4  write character
char3, char2, char1, char0  output  4 each  window, leftmost to rightmost digit, registered
char_update  output  1  one-cycle pulse in the cycle the char outputs take a reloaded value
paused  output  1  high in PAUSE
pos  output  clog2(MSG_LEN)  index of the character shown on char3

Behaviour:
- Single clock domain on clk. Reset is synchronous and active-high.
- Reset values:
  - state = RUN, pos = 0, tick counter = 0.
  - Message memory is reloaded with the default message, entry i = i mod 16.
  - char3..char0 = 0,1,2,3.
  - char_update = 0, paused = 0, both debouncer outputs = 0.
  - Reset applies mid-pause and mid-debounce with no exception.
- Window mapping: char3 = mem[pos], char2 = mem[pos+1], char1 = mem[pos+2], char0 = mem[pos+3]. All indices wrap modulo MSG_LEN.
- Output latency: char outputs are registered and reflect pos and mem as they stood after the previous edge, i.e. one cycle after any change. char_update is high for exactly that one cycle. It pulses even when the new values equal the old ones.
- Tick counter:
  - Counts 0..SCROLL_PERIOD-1, in RUN state only.
  - At SCROLL_PERIOD-1 it generates an advance and returns to 0.
  - It is held at 0 in PAUSE and restarts from 0 when RUN is re-entered.
- Advance: pos <= pos+1 mod MSG_LEN. After MSG_LEN-1 the next position is 0.
- State machine:
  - RUN -> PAUSE on a debounced btn_pause rising edge.
  - PAUSE -> RUN on a debounced btn_pause rising edge.
  - In PAUSE, a debounced btn_step rising edge performs one advance.
  - btn_step is ignored in RUN.
  - Falling edges are ignored.
- Simultaneous events:
  - Tick advance and pause edge in the same cycle: the advance is taken and the state becomes PAUSE.
  - Step and pause edge in the same cycle while in PAUSE: the advance is taken and the state becomes RUN.
  - msg_we in the same cycle as an advance: both are applied, and the reload uses the written data if the written address falls in the new window.
- Writes: mem[msg_wr_addr] <= msg_wr_data. If the address falls within the current window, the outputs reload on the next cycle with char_update. A write outside the window causes no reload.
- Debounce, per button:
  - Two-flop synchroniser, then a stability counter.
  - The debounced level flips after the synchronised input has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any mismatch gap clears the counter.
  - Latency from a clean raw edge to the debounced flip is 2+DEBOUNCE_CYCLES cycles. The resulting state or pos change appears one cycle later.

Decomposition:
- Shared include/package holds:
  - state encodings (RUN = 1'b0, PAUSE = 1'b1)
  - default-message function (entry i = i mod 16)
  - clog2 helper
- One natural sub-module: button_debouncer (parameter DEBOUNCE_CYCLES; ports clk, reset, btn_raw, btn_level, btn_rise), instantiated twice.

Test Plan:
Bench overrides SCROLL_PERIOD=4 and DEBOUNCE_CYCLES=3; clk period 10 ns.
1. Reset for 3 cycles, then release -> chars 0,1,2,3 and paused=0. Four cycles later pos=1; the next cycle chars=1,2,3,4 with a single-cycle char_update.
2. Free-run for 13 advances -> pos=13, chars D,E,F,0. Three more advances -> pos=0, chars 0,1,2,3 (wrap-around).
3. Hold btn_pause high for 8 cycles -> paused=1 within 6 cycles of the press. Chars stay frozen for 40 cycles. A btn_step press (held 8 cycles) advances pos by exactly 1. A second btn_pause press -> paused=0 and the tick counter restarts from 0.
4. Toggle btn_pause every 2 cycles for 20 cycles, then hold it low -> paused stays 0 and pos keeps advancing normally.
5. In PAUSE at pos=0, write msg_we with addr=1, data=A -> next cycle char2=A with a char_update pulse. A write to addr=9 -> no char_update.
6. Assert reset while in PAUSE at pos=5 after writing mem[0]=F -> chars 0,1,2,3, pos=0, paused=0, and mem[0] is restored to 0.
